// File: rtl/mvb_discard_stats_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mvb_discard_stats_pkg                                         |
// | Description : Shared constants and types for the MVB discard statistics    |
// |               block: MI register offsets, CTRL bit positions and the       |
// |               stage-1 per-word count type.                                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package mvb_discard_stats_pkg;

    // Largest REGIONS value the stage-1 count type is sized for.
    localparam int unsigned c_REGIONS_MAX = 16;

    // MI register byte offsets (32-bit words).
    localparam logic [31:0] c_ADDR_TOTAL_LO = 32'h0000_0000;
    localparam logic [31:0] c_ADDR_TOTAL_HI = 32'h0000_0004;
    localparam logic [31:0] c_ADDR_DISC_LO  = 32'h0000_0008;
    localparam logic [31:0] c_ADDR_DISC_HI  = 32'h0000_000C;
    localparam logic [31:0] c_ADDR_CTRL     = 32'h0000_0010;

    // CTRL register bit positions.
    localparam int unsigned c_CTRL_SNAPSHOT = 0;
    localparam int unsigned c_CTRL_CLEAR    = 1;

    // Number of items counted in one MVB word: $clog2(REGIONS+1) bits,
    // sized here for the largest supported region count.
    typedef logic [$clog2(c_REGIONS_MAX + 1)-1:0] stage1_cnt_t;

endpackage : mvb_discard_stats_pkg
`default_nettype wire

// File: rtl/mvb_discard_popcnt.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mvb_discard_popcnt                                           |
// | Description : Registered dual popcount of one MVB discard word. Counts     |
// |               valid items and valid-and-discarded items; both counts are   |
// |               forced to zero when no beat is transferred.                  |
// | Ports       : clk, rst_n (async, active-low)                               |
// |               i_beat        word transferred this cycle                    |
// |               i_vld/i_data  per-region valid / discard flag                |
// |               o_n_tot/o_n_dis registered counts                            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mvb_discard_popcnt
    import mvb_discard_stats_pkg::*;
#(
    parameter int REGIONS = 4
)(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_beat,
    input  logic [REGIONS-1:0] i_vld,
    input  logic [REGIONS-1:0] i_data,
    output stage1_cnt_t        o_n_tot,
    output stage1_cnt_t        o_n_dis
);

    stage1_cnt_t w_tot;
    stage1_cnt_t w_dis;
    stage1_cnt_t r_tot;
    stage1_cnt_t r_dis;

    // A discard flag only counts when its item is valid.
    always_comb begin
        w_tot = '0;
        w_dis = '0;
        for (int i = 0; i < REGIONS; i++) begin
            w_tot = w_tot + stage1_cnt_t'(i_vld[i]);
            w_dis = w_dis + stage1_cnt_t'(i_vld[i] & i_data[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tot <= '0;
            r_dis <= '0;
        end else begin
            r_tot <= i_beat ? w_tot : '0;
            r_dis <= i_beat ? w_dis : '0;
        end
    end

    assign o_n_tot = r_tot;
    assign o_n_dis = r_dis;

endmodule : mvb_discard_popcnt
`default_nettype wire

// File: rtl/mvb_discard_stats.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mvb_discard_stats                                            |
// | Description : Receiver of the RX MAC Lite MVB discard stream. Counts valid |
// |               and discarded frames in two CNT_WIDTH counters and exposes   |
// |               snapshots of them through an MI slave.                       |
// | Ports       : CLK, RESET_N (async, active-low)                             |
// |               MVB_DATA/MVB_VLD/MVB_SRC_RDY/MVB_DST_RDY  discard stream     |
// |               MI_DWR/MI_ADDR/MI_RD/MI_WR/MI_BE          MI request         |
// |               MI_DRD/MI_ARDY/MI_DRDY                    MI response        |
// | Registers   : 0x00 TOTAL_LO, 0x04 TOTAL_HI, 0x08 DISC_LO, 0x0C DISC_HI (RO)|
// |               0x10 CTRL (WO): bit0 SNAPSHOT, bit1 CLEAR                    |
// | Options     : MVB_DISCARD_STATS_SAT_EN - counters saturate instead of wrap |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mvb_discard_stats
    import mvb_discard_stats_pkg::*;
#(
    parameter int REGIONS       = 4,   // must not exceed c_REGIONS_MAX
    parameter int CNT_WIDTH     = 64,  // 33..64
    parameter int MI_DATA_WIDTH = 32,
    parameter int MI_ADDR_WIDTH = 32
)(
    input  logic                       CLK,
    input  logic                       RESET_N,
    input  logic [REGIONS-1:0]         MVB_DATA,
    input  logic [REGIONS-1:0]         MVB_VLD,
    input  logic                       MVB_SRC_RDY,
    output logic                       MVB_DST_RDY,
    input  logic [MI_DATA_WIDTH-1:0]   MI_DWR,
    input  logic [MI_ADDR_WIDTH-1:0]   MI_ADDR,
    input  logic                       MI_RD,
    input  logic                       MI_WR,
    input  logic [MI_DATA_WIDTH/8-1:0] MI_BE,
    output logic [MI_DATA_WIDTH-1:0]   MI_DRD,
    output logic                       MI_ARDY,
    output logic                       MI_DRDY
);

    logic                     r_active;
    logic                     w_beat;
    stage1_cnt_t              w_n_tot;
    stage1_cnt_t              w_n_dis;
    logic                     w_ctrl_wr;
    logic                     w_snapshot;
    logic                     w_clear;
    logic [CNT_WIDTH-1:0]     r_total;
    logic [CNT_WIDTH-1:0]     r_disc;
    logic [CNT_WIDTH-1:0]     r_snap_total;
    logic [CNT_WIDTH-1:0]     r_snap_disc;
    logic [63:0]              w_snap_total_ext;
    logic [63:0]              w_snap_disc_ext;
    logic [MI_DATA_WIDTH-1:0] w_rd_data;
    logic [MI_DATA_WIDTH-1:0] r_drd;
    logic                     r_drdy;
    logic                     w_unused;

    // Goes high on the first edge after reset release; gates every
    // handshake so nothing is accepted while reset is (or was just) active.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) r_active <= 1'b0;
        else          r_active <= 1'b1;
    end

    assign MVB_DST_RDY = r_active;
    assign w_beat      = MVB_SRC_RDY & r_active;
    assign MI_ARDY     = r_active & (MI_RD | MI_WR);

    mvb_discard_popcnt #(
        .REGIONS (REGIONS)
    ) u_popcnt (
        .clk     (CLK),
        .rst_n   (RESET_N),
        .i_beat  (w_beat),
        .i_vld   (MVB_VLD),
        .i_data  (MVB_DATA),
        .o_n_tot (w_n_tot),
        .o_n_dis (w_n_dis)
    );

    assign w_ctrl_wr  = r_active & MI_WR & MI_BE[0]
                      & (MI_ADDR == MI_ADDR_WIDTH'(c_ADDR_CTRL));
    assign w_snapshot = w_ctrl_wr & MI_DWR[c_CTRL_SNAPSHOT];
    assign w_clear    = w_ctrl_wr & MI_DWR[c_CTRL_CLEAR];

    function automatic logic [CNT_WIDTH-1:0] acc_add(
        input logic [CNT_WIDTH-1:0] a,
        input stage1_cnt_t          n
    );
`ifdef MVB_DISCARD_STATS_SAT_EN
        logic [CNT_WIDTH:0] sum;
        sum = {1'b0, a} + (CNT_WIDTH+1)'(n);
        // Carry out means the add crossed the maximum: pin to all ones.
        return sum[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : sum[CNT_WIDTH-1:0];
`else
        return a + CNT_WIDTH'(n);
`endif
    endfunction

    // Clear wins over the stage-2 add of the same edge; the stage-1 register
    // is untouched, so its contents land on the next edge.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_total <= '0;
            r_disc  <= '0;
        end else if (w_clear) begin
            r_total <= '0;
            r_disc  <= '0;
        end else begin
            r_total <= acc_add(r_total, w_n_tot);
            r_disc  <= acc_add(r_disc,  w_n_dis);
        end
    end

    // Samples the current (pre-clear, pre-add) live values.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_snap_total <= '0;
            r_snap_disc  <= '0;
        end else if (w_snapshot) begin
            r_snap_total <= r_total;
            r_snap_disc  <= r_disc;
        end
    end

    assign w_snap_total_ext = 64'(r_snap_total);
    assign w_snap_disc_ext  = 64'(r_snap_disc);

    always_comb begin
        w_rd_data = '0;
        if (MI_ADDR == MI_ADDR_WIDTH'(c_ADDR_TOTAL_LO))
            w_rd_data = w_snap_total_ext[31:0];
        else if (MI_ADDR == MI_ADDR_WIDTH'(c_ADDR_TOTAL_HI))
            w_rd_data = w_snap_total_ext[63:32];
        else if (MI_ADDR == MI_ADDR_WIDTH'(c_ADDR_DISC_LO))
            w_rd_data = w_snap_disc_ext[31:0];
        else if (MI_ADDR == MI_ADDR_WIDTH'(c_ADDR_DISC_HI))
            w_rd_data = w_snap_disc_ext[63:32];
    end

    // Read data is taken from the snapshot registers before this edge's
    // write lands, so a same-cycle RD+WR returns the old contents.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_drd  <= '0;
            r_drdy <= 1'b0;
        end else begin
            r_drdy <= r_active & MI_RD;
            if (r_active & MI_RD) r_drd <= w_rd_data;
        end
    end

    assign MI_DRD  = r_drd;
    assign MI_DRDY = r_drdy;

    assign w_unused = ^{MI_BE[MI_DATA_WIDTH/8-1:1], MI_DWR[MI_DATA_WIDTH-1:2]};

endmodule : mvb_discard_stats
`default_nettype wire

// File: tb/tb_mvb_discard_stats.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_mvb_discard_stats                                         |
// | Description : Self-checking bench for mvb_discard_stats. Stimulus drives   |
// |               MVB beats and MI accesses; expected read data is queued and  |
// |               a negedge monitor compares every MI_DRDY response.           |
// | Options     : MVB_DISCARD_STATS_SAT_EN selects the saturating model        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_mvb_discard_stats;

    localparam int          REGIONS   = 4;
    localparam int          CNT_WIDTH = 64;
    localparam int          AW        = 32;
    localparam logic [63:0] c_MAX     = 64'hFFFF_FFFF_FFFF_FFFF;

    logic               CLK = 1'b0;
    logic               RESET_N = 1'b1;
    logic [REGIONS-1:0] MVB_DATA = '0;
    logic [REGIONS-1:0] MVB_VLD = '0;
    logic               MVB_SRC_RDY = 1'b0;
    logic               MVB_DST_RDY;
    logic [31:0]        MI_DWR = '0;
    logic [AW-1:0]      MI_ADDR = '0;
    logic               MI_RD = 1'b0;
    logic               MI_WR = 1'b0;
    logic [3:0]         MI_BE = '0;
    logic [31:0]        MI_DRD;
    logic               MI_ARDY;
    logic               MI_DRDY;

    always #5 CLK = ~CLK;

    mvb_discard_stats #(
        .REGIONS       (REGIONS),
        .CNT_WIDTH     (CNT_WIDTH),
        .MI_DATA_WIDTH (32),
        .MI_ADDR_WIDTH (AW)
    ) dut (
        .CLK         (CLK),
        .RESET_N     (RESET_N),
        .MVB_DATA    (MVB_DATA),
        .MVB_VLD     (MVB_VLD),
        .MVB_SRC_RDY (MVB_SRC_RDY),
        .MVB_DST_RDY (MVB_DST_RDY),
        .MI_DWR      (MI_DWR),
        .MI_ADDR     (MI_ADDR),
        .MI_RD       (MI_RD),
        .MI_WR       (MI_WR),
        .MI_BE       (MI_BE),
        .MI_DRD      (MI_DRD),
        .MI_ARDY     (MI_ARDY),
        .MI_DRDY     (MI_DRDY)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    // Counters are described as "base value plus every accepted beat from
    // base_from onward that has had two cycles to reach the counters".
    typedef struct { int t; int ntot; int ndis; } beat_t;
    typedef struct { logic [31:0] data; int cyc; logic [31:0] addr; } exp_t;

    beat_t       beats[$];
    exp_t        sb_q[$];
    logic [63:0] base_tot, base_dis, snap_tot, snap_dis;
    int          base_from;
    bit          model_active;

    function automatic logic [63:0] madd(input logic [63:0] a, input int n);
`ifdef MVB_DISCARD_STATS_SAT_EN
        if (c_MAX - a < 64'(n)) return c_MAX;
`endif
        return a + 64'(n);
    endfunction

    task automatic live(input int s, output logic [63:0] tot, output logic [63:0] dis);
        tot = base_tot;
        dis = base_dis;
        foreach (beats[i])
            if (beats[i].t >= base_from && beats[i].t <= s - 2) begin
                tot = madd(tot, beats[i].ntot);
                dis = madd(dis, beats[i].ndis);
            end
    endtask

    function automatic logic [31:0] reg_value(input logic [31:0] addr);
        case (addr)
            32'h00:  return snap_tot[31:0];
            32'h04:  return snap_tot[63:32];
            32'h08:  return snap_dis[31:0];
            32'h0C:  return snap_dis[63:32];
            default: return 32'h0;
        endcase
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    // One clock cycle of stimulus; updates model and scoreboard.
    task automatic do_cycle(input logic src, input logic [3:0] vld, input logic [3:0] data,
                            input logic rd, input logic wr, input logic [31:0] addr,
                            input logic [31:0] dwr, input logic [3:0] be);
        logic [63:0] lt, ld;
        MVB_SRC_RDY = src; MVB_VLD = vld; MVB_DATA = data;
        MI_RD = rd; MI_WR = wr; MI_ADDR = addr; MI_DWR = dwr; MI_BE = be;
        if (model_active) begin
            if (src)
                beats.push_back('{t: cyc, ntot: $countones(vld), ndis: $countones(vld & data)});
            if (rd)
                sb_q.push_back('{data: reg_value(addr), cyc: cyc + 1, addr: addr});
            if (wr && addr == 32'h10 && be[0]) begin
                live(cyc, lt, ld);
                if (dwr[0]) begin snap_tot = lt; snap_dis = ld; end
                if (dwr[1]) begin base_tot = '0; base_dis = '0; base_from = cyc; end
            end
        end
        #1;
        if (model_active && (rd || wr)) check("ardy", MI_ARDY, 1'b1);
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) do_cycle(0, 4'h0, 4'h0, 0, 0, 0, 0, 4'h0);
    endtask
    task automatic beat(input logic [3:0] vld, input logic [3:0] data);
        do_cycle(1, vld, data, 0, 0, 0, 0, 4'h0);
    endtask
    task automatic mi_read(input logic [31:0] addr);
        do_cycle(0, 4'h0, 4'h0, 1, 0, addr, 0, 4'h0);
    endtask
    task automatic mi_ctrl(input logic [31:0] dwr);
        do_cycle(0, 4'h0, 4'h0, 0, 1, 32'h10, dwr, 4'hF);
    endtask
    task automatic read_all();
        mi_read(32'h00); mi_read(32'h04); mi_read(32'h08); mi_read(32'h0C);
    endtask

    task automatic apply_reset();
        RESET_N = 1'b0;
        model_active = 0;
        sb_q.delete();
        beats.delete();
        base_tot = '0; base_dis = '0; base_from = 0; snap_tot = '0; snap_dis = '0;
        // Activity during reset must be ignored.
        MVB_SRC_RDY = 1; MVB_VLD = '1; MVB_DATA = '1; MI_RD = 1; MI_WR = 0;
        #1;
        check("rst_drdy", MI_DRDY, 1'b0);
        check("rst_drd", MI_DRD, 32'h0);
        check("rst_dst_rdy", MVB_DST_RDY, 1'b0);
        check("rst_ardy", MI_ARDY, 1'b0);
        tick(); tick(); tick();
        MVB_SRC_RDY = 0; MVB_VLD = '0; MVB_DATA = '0; MI_RD = 0;
        RESET_N = 1'b1;
        tick();
        model_active = 1;
        check("dst_rdy_after_reset", MVB_DST_RDY, 1'b1);
    endtask

    // ---------------- monitor ----------------
    always @(negedge CLK) begin
        exp_t e;
        if (MI_DRDY) begin
            if (sb_q.size() == 0) begin
                n_checks++; n_errors++;
                $display("FAIL unexpected_drdy: got DRDY=1 with data 0x%0h, expected none (cycle %0d)", MI_DRD, cyc);
            end else begin
                e = sb_q.pop_front();
                check("drdy_latency", 64'(cyc), 64'(e.cyc));
                check($sformatf("rd_0x%0h", e.addr), 64'(MI_DRD), 64'(e.data));
            end
        end else if (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
            e = sb_q.pop_front();
            n_checks++; n_errors++;
            $display("FAIL missing_drdy: got DRDY=0 for read of 0x%0h, expected 1 (cycle %0d)", e.addr, cyc);
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] addrs [7];
        logic [63:0] lt, ld;
        addrs = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h40};
        #2;
        apply_reset();

        // Reset values through MI.
        read_all();
        idle(2);

        // 10 full beats, half discarded: TOTAL 40, DISC 20.
        for (int i = 0; i < 10; i++) beat(4'hF, 4'h5);
        idle(2);
        mi_ctrl(32'h1);
        read_all();

        // DATA without VLD ignored; beat with SRC_RDY=0 ignored.
        beat(4'h3, 4'hC);
        do_cycle(0, 4'hF, 4'hF, 0, 0, 0, 0, 4'h0);
        idle(2);
        mi_ctrl(32'h1);
        mi_read(32'h00); mi_read(32'h08);

        // Snapshot at t+1 misses the beat, at t+2 sees it; the read
        // issued with the second snapshot still returns the first one.
        beat(4'hF, 4'h0);
        mi_ctrl(32'h1);
        do_cycle(0, 4'h0, 4'h0, 1, 1, 32'h10, 32'h1, 4'h1);
        mi_read(32'h00);
        mi_read(32'h00);

        // Clear, 5 full beats, snapshot+clear, then an empty snapshot.
        mi_ctrl(32'h2);
        idle(2);
        for (int i = 0; i < 5; i++) beat(4'hF, 4'hF);
        idle(2);
        mi_ctrl(32'h3);
        mi_read(32'h00); mi_read(32'h08);
        idle(3);
        mi_ctrl(32'h1);
        mi_read(32'h00); mi_read(32'h08);

        // Randomized traffic and MI accesses, including unmapped
        // addresses, BE[0]=0 writes and combined RD+WR.
        for (int i = 0; i < 400; i++) begin
            int r;
            logic rd, wr;
            logic [31:0] a, d;
            r  = int'($urandom_range(0, 9));
            rd = (r < 3) || (r == 9);
            wr = (r >= 7);
            a  = wr ? (($urandom_range(0, 3) != 0) ? 32'h10 : addrs[$urandom_range(0, 6)])
                    : addrs[$urandom_range(0, 6)];
            d  = $urandom;
            d[1] = ($urandom_range(0, 7) == 0);
            do_cycle(($urandom_range(0, 3) != 0), 4'($urandom), 4'($urandom),
                     rd, wr, a, d, ($urandom_range(0, 4) == 0) ? 4'hE : 4'($urandom) | 4'h1);
        end
        idle(3);
        mi_ctrl(32'h1);
        read_all();

        // Preload TOTAL just below the maximum, then add 4.
        idle(3);
        live(cyc, lt, ld);
        force dut.r_total = c_MAX - 64'd1;
        #1;
        release dut.r_total;
        base_tot = c_MAX - 64'd1; base_dis = ld; base_from = cyc;
        tick();
        beat(4'hF, 4'h0);
        idle(2);
        mi_ctrl(32'h1);
        read_all();

        // Reset mid-operation: pending DRDY cancelled, everything zeroed.
        for (int i = 0; i < 3; i++) beat(4'hF, 4'h9);
        idle(2);
        mi_read(32'h00);
        apply_reset();
        idle(1);
        mi_ctrl(32'h1);
        read_all();
        idle(3);

        check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_mvb_discard_stats
`default_nettype wire
